// File: rtl/l2_arb_pkg.sv
// Shared types and the round-robin search used by the L2 port arbiter.
// The arbiter supports up to MAX_PORTS requesters.
package l2_arb_pkg;

  localparam int MAX_PORTS = 8;

  typedef enum logic [1:0] {IDLE, BUSY, RECOVER} state_t;

  // The search starts at ptr and walks upward, wrapping modulo n.
  // A ptr of 0 gives lowest-index-wins fixed priority.
  function automatic logic rr_next(input logic [MAX_PORTS-1:0] req, input int ptr,
                                   input int n, output int idx);
    logic found;
    int   j;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < MAX_PORTS; k++) begin
      j = (ptr + k) % n;
      if (k < n && !found && req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational priority picker: round-robin from ptr, or fixed priority
// (lowest index wins) when RR_EN is 0.
module rr_picker
  import l2_arb_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter bit RR_EN   = 1'b1,
  localparam int PW     = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic               found,
  output logic [PW-1:0]      idx
);

  int idx_i;

  always_comb begin
    idx_i = 0;
    found = rr_next(MAX_PORTS'(req), RR_EN ? int'(ptr) : 0, N_PORTS, idx_i);
    idx   = PW'(idx_i);
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// N-port arbiter multiplexing L1 line requests onto one registered L2 port,
// with a single recovery cycle after each L2 response.
module l2_port_arbiter
  import l2_arb_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 16,
  parameter int LINE_W  = 128,
  parameter bit RR_EN   = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_PORTS-1:0]        req_read,
  input  logic [N_PORTS-1:0]        req_write,
  input  logic [N_PORTS*ADDR_W-1:0] req_addr,
  input  logic [N_PORTS*LINE_W-1:0] req_wdata,
  output logic [LINE_W-1:0]         req_rdata,
  output logic [N_PORTS-1:0]        req_resp,
  output logic                      l2_read,
  output logic                      l2_write,
  output logic [ADDR_W-1:0]         l2_addr,
  output logic [LINE_W-1:0]         l2_wdata,
  input  logic [LINE_W-1:0]         l2_rdata,
  input  logic                      l2_resp,
  output logic                      busy
);

  localparam int PW = $clog2(N_PORTS);

  state_t        state, state_nx;
  logic [PW-1:0] ptr, grant, pick, grant_inc;
  logic          found;

  rr_picker #(.N_PORTS(N_PORTS), .RR_EN(RR_EN)) u_pick (
    .req   (req_read | req_write),
    .ptr   (ptr),
    .found (found),
    .idx   (pick)
  );

  assign grant_inc = (grant == PW'(N_PORTS - 1)) ? '0 : grant + PW'(1);
  assign req_rdata = l2_rdata;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found)   state_nx = BUSY;
      BUSY:    if (l2_resp) state_nx = RECOVER;
      RECOVER:              state_nx = IDLE;
      default:              state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_resp = '0;
    if (state == BUSY && l2_resp) req_resp[grant] = 1'b1;
  end

  // A port raising both read and write is served as a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      grant    <= '0;
      l2_read  <= 1'b0;
      l2_write <= 1'b0;
      l2_addr  <= '0;
      l2_wdata <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (found) begin
          grant    <= pick;
          l2_addr  <= req_addr[int'(pick)*ADDR_W +: ADDR_W];
          l2_wdata <= req_wdata[int'(pick)*LINE_W +: LINE_W];
          l2_write <= req_write[pick];
          l2_read  <= ~req_write[pick];
        end
        BUSY: if (l2_resp) begin
          l2_read  <= 1'b0;
          l2_write <= 1'b0;
          l2_addr  <= '0;
          l2_wdata <= '0;
          if (RR_EN) ptr <= grant_inc;
        end
        default: ;
      endcase
    end
  end

  a_no_rw_both: assert property (@(posedge clk) disable iff (!rst_n)
    (req_read & req_write) == '0);

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench: three arbiter instances (2-port RR, 2-port fixed, 4-port RR).
module tb_l2_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // 2-port round-robin instance
  logic [1:0]   a_req_read, a_req_write, a_resp;
  logic [31:0]  a_req_addr;
  logic [255:0] a_req_wdata;
  logic [127:0] a_rdata, a_l2_wdata, a_l2_rdata;
  logic         a_l2_read, a_l2_write, a_l2_resp, a_busy;
  logic [15:0]  a_l2_addr;

  // 2-port fixed-priority instance
  logic [1:0]   b_req_read, b_req_write, b_resp;
  logic [31:0]  b_req_addr;
  logic [255:0] b_req_wdata;
  logic [127:0] b_rdata, b_l2_wdata, b_l2_rdata;
  logic         b_l2_read, b_l2_write, b_l2_resp, b_busy;
  logic [15:0]  b_l2_addr;

  // 4-port round-robin instance
  logic [3:0]   c_req_read, c_req_write, c_resp;
  logic [63:0]  c_req_addr;
  logic [511:0] c_req_wdata;
  logic [127:0] c_rdata, c_l2_wdata, c_l2_rdata;
  logic         c_l2_read, c_l2_write, c_l2_resp, c_busy;
  logic [15:0]  c_l2_addr;

  l2_port_arbiter #(.N_PORTS(2), .ADDR_W(16), .LINE_W(128), .RR_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_read(a_req_read), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_rdata(a_rdata), .req_resp(a_resp),
    .l2_read(a_l2_read), .l2_write(a_l2_write), .l2_addr(a_l2_addr), .l2_wdata(a_l2_wdata),
    .l2_rdata(a_l2_rdata), .l2_resp(a_l2_resp), .busy(a_busy));

  l2_port_arbiter #(.N_PORTS(2), .ADDR_W(16), .LINE_W(128), .RR_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_read(b_req_read), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_rdata(b_rdata), .req_resp(b_resp),
    .l2_read(b_l2_read), .l2_write(b_l2_write), .l2_addr(b_l2_addr), .l2_wdata(b_l2_wdata),
    .l2_rdata(b_l2_rdata), .l2_resp(b_l2_resp), .busy(b_busy));

  l2_port_arbiter #(.N_PORTS(4), .ADDR_W(16), .LINE_W(128), .RR_EN(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .req_read(c_req_read), .req_write(c_req_write),
    .req_addr(c_req_addr), .req_wdata(c_req_wdata), .req_rdata(c_rdata), .req_resp(c_resp),
    .l2_read(c_l2_read), .l2_write(c_l2_write), .l2_addr(c_l2_addr), .l2_wdata(c_l2_wdata),
    .l2_rdata(c_l2_rdata), .l2_resp(c_l2_resp), .busy(c_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_req_read = '0; a_req_write = '0; a_req_addr = '0; a_req_wdata = '0;
    a_l2_rdata = '0; a_l2_resp = 1'b0;
    b_req_read = '0; b_req_write = '0; b_req_addr = '0; b_req_wdata = '0;
    b_l2_rdata = '0; b_l2_resp = 1'b0;
    c_req_read = '0; c_req_write = '0; c_req_addr = '0; c_req_wdata = '0;
    c_l2_rdata = '0; c_l2_resp = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Bounded waits for an L2 command; each returns at a negedge.
  task automatic wait_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (a_l2_read || a_l2_write) ok = 1'b1;
    end
  endtask

  task automatic wait_b(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (b_l2_read || b_l2_write) ok = 1'b1;
    end
  endtask

  task automatic wait_c(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (c_l2_read || c_l2_write) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #12;
    total++; if (a_l2_read !== 1'b0) $display("FAIL rst_a_l2_read got %b exp 0", a_l2_read); else passed++;
    total++; if (a_l2_write !== 1'b0) $display("FAIL rst_a_l2_write got %b exp 0", a_l2_write); else passed++;
    total++; if (a_l2_addr !== 16'h0) $display("FAIL rst_a_l2_addr got %h exp 0", a_l2_addr); else passed++;
    total++; if (a_l2_wdata !== 128'h0) $display("FAIL rst_a_l2_wdata got %h exp 0", a_l2_wdata); else passed++;
    total++; if (a_resp !== 2'b00) $display("FAIL rst_a_resp got %b exp 00", a_resp); else passed++;
    total++; if (a_busy !== 1'b0) $display("FAIL rst_a_busy got %b exp 0", a_busy); else passed++;
    total++; if (b_busy !== 1'b0) $display("FAIL rst_b_busy got %b exp 0", b_busy); else passed++;
    total++; if (c_busy !== 1'b0) $display("FAIL rst_c_busy got %b exp 0", c_busy); else passed++;
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    total++; if (a_busy !== 1'b0 || a_l2_read !== 1'b0) $display("FAIL idle_a got busy=%b rd=%b exp 0 0", a_busy, a_l2_read); else passed++;
  endtask

  task automatic test_single_read();
    bit ok;
    apply_reset();
    tick();
    a_req_read = 2'b01;
    a_req_addr = {16'h0000, 16'h1230};
    @(negedge clk);
    total++; if (a_l2_read !== 1'b0) $display("FAIL rd_before_pick got %b exp 0", a_l2_read); else passed++;
    @(negedge clk);
    total++; if (a_l2_read !== 1'b1) $display("FAIL rd_l2_read got %b exp 1", a_l2_read); else passed++;
    total++; if (a_l2_write !== 1'b0) $display("FAIL rd_l2_write got %b exp 0", a_l2_write); else passed++;
    total++; if (a_l2_addr !== 16'h1230) $display("FAIL rd_l2_addr got %h exp 1230", a_l2_addr); else passed++;
    total++; if (a_busy !== 1'b1) $display("FAIL rd_busy got %b exp 1", a_busy); else passed++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (a_l2_read !== 1'b1 || a_resp !== 2'b00) $display("FAIL rd_hold got rd=%b resp=%b exp 1 00", a_l2_read, a_resp); else passed++;
    end
    tick();
    a_l2_resp = 1'b1;
    a_l2_rdata = {16{8'hA5}};
    @(negedge clk);
    total++; if (a_resp !== 2'b01) $display("FAIL rd_resp got %b exp 01", a_resp); else passed++;
    total++; if (a_rdata !== {16{8'hA5}}) $display("FAIL rd_rdata got %h exp a5..a5", a_rdata); else passed++;
    tick();
    a_l2_resp = 1'b0;
    a_req_read = 2'b00;
    @(negedge clk);
    total++; if (a_resp !== 2'b00) $display("FAIL rd_resp_once got %b exp 00", a_resp); else passed++;
    total++; if (a_l2_read !== 1'b0 || a_busy !== 1'b1) $display("FAIL rd_recover got rd=%b busy=%b exp 0 1", a_l2_read, a_busy); else passed++;
    @(negedge clk);
    total++; if (a_busy !== 1'b0) $display("FAIL rd_back_idle got %b exp 0", a_busy); else passed++;
    ok = 1'b1;
  endtask

  task automatic test_contention_rr();
    bit ok;
    logic [15:0] exp_addr;
    logic [1:0]  exp_resp;
    apply_reset();
    tick();
    a_req_read = 2'b11;
    a_req_addr = {16'h2000, 16'h1000};
    for (int t = 0; t < 4; t++) begin
      exp_addr = (t % 2 == 1) ? 16'h2000 : 16'h1000;
      exp_resp = (t % 2 == 1) ? 2'b10 : 2'b01;
      wait_a(ok);
      total++; if (!ok) $display("FAIL rr_timeout txn %0d got no cmd exp l2_read", t); else passed++;
      total++; if (a_l2_addr !== exp_addr) $display("FAIL rr_addr txn %0d got %h exp %h", t, a_l2_addr, exp_addr); else passed++;
      tick();
      a_l2_resp = 1'b1;
      @(negedge clk);
      total++; if (a_resp !== exp_resp) $display("FAIL rr_grant txn %0d got %b exp %b", t, a_resp, exp_resp); else passed++;
      tick();
      a_l2_resp = 1'b0;
      @(negedge clk);
      total++; if (a_busy !== 1'b1 || a_l2_read !== 1'b0) $display("FAIL rr_recover txn %0d got busy=%b rd=%b exp 1 0", t, a_busy, a_l2_read); else passed++;
      if (t < 3) begin
        @(negedge clk);
        total++; if (a_l2_read !== 1'b0 || a_busy !== 1'b0) $display("FAIL rr_idle_gap txn %0d got rd=%b busy=%b exp 0 0", t, a_l2_read, a_busy); else passed++;
      end
    end
    a_req_read = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_contention_fixed();
    bit ok;
    apply_reset();
    tick();
    b_req_read = 2'b11;
    b_req_addr = {16'h2000, 16'h1000};
    for (int t = 0; t < 4; t++) begin
      wait_b(ok);
      total++; if (!ok) $display("FAIL fp_timeout txn %0d got no cmd exp l2_read", t); else passed++;
      total++; if (b_l2_addr !== ((t == 3) ? 16'h2000 : 16'h1000)) $display("FAIL fp_addr txn %0d got %h exp %h", t, b_l2_addr, (t == 3) ? 16'h2000 : 16'h1000); else passed++;
      tick();
      b_l2_resp = 1'b1;
      @(negedge clk);
      total++; if (b_resp !== ((t == 3) ? 2'b10 : 2'b01)) $display("FAIL fp_grant txn %0d got %b exp %b", t, b_resp, (t == 3) ? 2'b10 : 2'b01); else passed++;
      tick();
      b_l2_resp = 1'b0;
      if (t == 2) b_req_read = 2'b10;
      if (t == 3) b_req_read = 2'b00;
    end
    tick();
    tick();
  endtask

  task automatic test_write();
    bit ok;
    logic [127:0] line;
    line = 128'h0123456789ABCDEF0123456789ABCDEF;
    apply_reset();
    tick();
    a_req_write = 2'b10;
    a_req_addr = {16'h0040, 16'h0000};
    a_req_wdata = {line, 128'h0};
    wait_a(ok);
    total++; if (!ok) $display("FAIL wr_timeout got no cmd exp l2_write"); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++; if (a_l2_write !== 1'b1 || a_l2_read !== 1'b0) $display("FAIL wr_cmd cyc %0d got wr=%b rd=%b exp 1 0", i, a_l2_write, a_l2_read); else passed++;
      total++; if (a_l2_wdata !== line) $display("FAIL wr_wdata cyc %0d got %h exp %h", i, a_l2_wdata, line); else passed++;
      total++; if (a_l2_addr !== 16'h0040) $display("FAIL wr_addr cyc %0d got %h exp 0040", i, a_l2_addr); else passed++;
      @(negedge clk);
    end
    a_l2_resp = 1'b1;
    #1;
    total++; if (a_resp !== 2'b10) $display("FAIL wr_resp got %b exp 10", a_resp); else passed++;
    tick();
    a_l2_resp = 1'b0;
    a_req_write = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_busy();
    bit ok;
    apply_reset();
    tick();
    a_req_read = 2'b01;
    a_req_addr = {16'h0000, 16'h0ABC};
    wait_a(ok);
    total++; if (!ok) $display("FAIL rmb_timeout got no cmd exp l2_read"); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (a_l2_read !== 1'b0) $display("FAIL rmb_l2_read got %b exp 0", a_l2_read); else passed++;
    total++; if (a_busy !== 1'b0) $display("FAIL rmb_busy got %b exp 0", a_busy); else passed++;
    a_req_read = 2'b00;
    #2;
    rst_n = 1'b1;
    tick();
    a_l2_resp = 1'b1;
    @(negedge clk);
    total++; if (a_resp !== 2'b00) $display("FAIL rmb_late_resp got %b exp 00", a_resp); else passed++;
    total++; if (a_busy !== 1'b0 || a_l2_read !== 1'b0) $display("FAIL rmb_idle got busy=%b rd=%b exp 0 0", a_busy, a_l2_read); else passed++;
    tick();
    a_l2_resp = 1'b0;
  endtask

  task automatic test_four_port_rr();
    bit ok;
    logic [15:0] exp_addr;
    logic [3:0]  exp_resp;
    apply_reset();
    tick();
    c_req_read = 4'b1111;
    c_req_addr = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    for (int k = 0; k < 5; k++) begin
      exp_addr = 16'h0100 * 16'(k % 4 + 1);
      exp_resp = 4'(1 << (k % 4));
      wait_c(ok);
      total++; if (!ok) $display("FAIL rr4_timeout txn %0d got no cmd exp l2_read", k); else passed++;
      total++; if (c_l2_addr !== exp_addr) $display("FAIL rr4_addr txn %0d got %h exp %h", k, c_l2_addr, exp_addr); else passed++;
      if (k == 0) begin
        c_req_addr[15:0] = 16'hBEEF;
        @(negedge clk);
        total++; if (c_l2_addr !== 16'h0100) $display("FAIL rr4_addr_hold got %h exp 0100", c_l2_addr); else passed++;
        c_req_addr[15:0] = 16'h0100;
      end
      tick();
      c_l2_resp = 1'b1;
      @(negedge clk);
      total++; if (c_resp !== exp_resp) $display("FAIL rr4_grant txn %0d got %b exp %b", k, c_resp, exp_resp); else passed++;
      tick();
      c_l2_resp = 1'b0;
    end
    c_req_read = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention_rr();
    test_contention_fixed();
    test_write();
    test_reset_mid_busy();
    test_four_port_rr();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule
